dbg_cmd_decoder: RTL and testbench
==================================

DBG_CMD_DECODER -- requirements
Module: dbg_cmd_decoder

Interface
REQ-001 SHALL have parameter CMD_WRITE, default 8'h10, which is the write-frame command byte.
REQ-002 SHALL have parameter CMD_READ, default 8'h11, which is the read-frame command byte.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port rx_data_i, input, 8 bits: received UART byte.
REQ-006 SHALL have port rx_valid_i, input, 1 bit: rx_data_i is valid.
REQ-007 SHALL have port rx_accept_o, output, 1 bit: byte consumed when rx_valid_i && rx_accept_o.
REQ-008 SHALL have port tx_data_o, output, 8 bits: response byte to the UART TX FIFO.
REQ-009 SHALL have port tx_valid_o, output, 1 bit: tx_data_o is valid.
REQ-010 SHALL have port tx_accept_i, input, 1 bit: byte taken when tx_valid_o && tx_accept_i.
REQ-011 SHALL have port mem_addr_o, output, 32 bits: request address.
REQ-012 SHALL have ports mem_wr_o and mem_rd_o, outputs, 1 bit each: write and read request strobes.
REQ-013 SHALL have port mem_wdata_o, output, 32 bits, and port mem_wstrb_o, output, 4 bits: write data and byte strobes (bit3 = [31:24]).
REQ-014 SHALL have port mem_accept_i, input, 1 bit: request taken this cycle.
REQ-015 SHALL have port mem_ack_i, input, 1 bit, and port mem_rdata_i, input, 32 bits: read data return.
REQ-016 SHALL have port busy_o, output, 1 bit: high while not in IDLE.
REQ-017 SHALL have port err_o, output, 1 bit: one-cycle pulse when an unknown command byte is received.

Function
REQ-018 Frame format SHALL be: CMD, LEN (data byte count, 0-255), ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], then LEN data bytes for writes only.
REQ-019 The FSM states SHALL be IDLE, LEN, ADDR, WDATA, WREQ, RREQ, RWAIT and RSEND, with IDLE as the reset state.
REQ-020 rx_accept_o SHALL be 1 in IDLE, LEN, ADDR and WDATA, and 0 in all other states.
REQ-021 In IDLE, a consumed byte equal to CMD_WRITE or CMD_READ SHALL latch the direction and move to LEN; any other byte SHALL pulse err_o for the following cycle and stay in IDLE.
REQ-022 LEN SHALL latch the count and go to ADDR; ADDR SHALL shift in 4 bytes, MSB first, using a 2-bit index.
REQ-023 After the 4th address byte: write with LEN=0 or read with LEN=0 SHALL return to IDLE with no memory request; write with LEN>0 SHALL go to WDATA; read with LEN>0 SHALL go to RREQ.
REQ-024 In WDATA, byte k of a word (k=0..3) SHALL be placed in bits [31-8k:24-8k] with strobe bit 3-k set, and unfilled lanes SHALL be 0 with strobe 0.
REQ-025 WDATA SHALL go to WREQ after the 4th byte of a word or after the final frame byte, whichever comes first.
REQ-026 In WREQ, mem_wr_o SHALL be 1 with addr, data and strobe held stable until mem_accept_i.
REQ-027 On accept in WREQ: the address SHALL increment by 4 (mod 2^32), the packer SHALL clear, and the FSM SHALL go to WDATA if bytes remain, else IDLE.
REQ-028 The address low bits SHALL be passed through unmodified.
REQ-029 In RREQ, mem_rd_o SHALL be held until mem_accept_i and then go to RWAIT.
REQ-030 In RWAIT, on mem_ack_i the FSM SHALL capture mem_rdata_i and go to RSEND; mem_ack_i in the same cycle as accept SHALL be captured directly and skip RWAIT.
REQ-031 RSEND SHALL emit min(4, remaining) bytes, MSB first, with tx_valid_o held and tx_data_o stable until tx_accept_i.
REQ-032 After RSEND: the address SHALL add 4, and the FSM SHALL go to RREQ if bytes remain, else IDLE.
REQ-033 The remaining-byte counter SHALL be 8 bits and decrement once per consumed write byte or accepted read byte; it SHALL never wrap below 0.
REQ-034 mem_wr_o and mem_rd_o SHALL never both be 1; at most one request SHALL be outstanding.
REQ-035 The block SHALL have no timeout; a stalled frame waits indefinitely and reset is the only abort.

Reset
REQ-036 When rst_i=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-037 During reset, rx_accept_o, tx_valid_o, mem_wr_o, mem_rd_o, busy_o and err_o SHALL be 0, and mem_addr_o, mem_wdata_o, mem_wstrb_o, tx_data_o, counters and packer SHALL be 0.
REQ-038 Reset mid-frame or mid-request SHALL drop the frame; the next byte after reset SHALL be parsed as a CMD.

Verification
REQ-039 Write frame 10 0D 00 00 00 40 + bytes 01..0D, mem_accept_i=1 -> writes at 0x40/44/48/4C with data 01020304, 05060708, 090A0B0C, 0D000000 and strobe F, F, F, 8, then IDLE.
REQ-040 Read frame 11 06 00 00 01 00, ack returns AABBCCDD then 11223344 -> reads at 0x100 and 0x104, tx bytes AA BB CC DD 11 22, and no 33/44.
REQ-041 Byte 0x55 in IDLE -> err_o pulses for 1 cycle, no memory request, and the next 10 00 00 00 00 00 completes silently.
REQ-042 With mem_accept_i low for 5 cycles during WREQ -> mem_wr_o, addr, data and strobe are stable for all 5 cycles, rx_accept_o=0, and exactly one write is issued.
REQ-043 With tx_accept_i toggling every other cycle during RSEND -> no byte is duplicated or lost.
REQ-044 With rst_i=0 for 1 cycle after the 3rd address byte -> all outputs are 0, no request is issued, and a following full write frame executes normally.

Source files
------------

// File: rtl/dbg_cmd_decoder.sv
// Debug command decoder: parses CMD/LEN/ADDR(/DATA) frames from a UART byte
// stream and turns them into 32-bit memory writes and reads, streaming read data back.
module dbg_cmd_decoder #(
    parameter logic [7:0] CMD_WRITE = 8'h10,
    parameter logic [7:0] CMD_READ  = 8'h11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_accept_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_accept_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and
    // accept/ready are both 1; the source holds data stable until then.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WREQ, S_RREQ, S_RWAIT, S_RSEND
    } state_t;

    state_t      state_q, state_d;
    logic        is_write_q;
    logic [7:0]  remain_q;
    logic [1:0]  idx_q;
    logic [1:0]  lane;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        err_q;
    logic        rx_ready;
    logic        is_cmd;

    assign lane     = 2'd3 - idx_q;
    assign is_cmd   = (rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ);
    assign rx_ready = (state_q == S_IDLE) || (state_q == S_LEN) ||
                      (state_q == S_ADDR) || (state_q == S_WDATA);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rx_valid_i && is_cmd) state_d = S_LEN;
            S_LEN:   if (rx_valid_i) state_d = S_ADDR;
            S_ADDR:
                if (rx_valid_i && idx_q == 2'd3) begin
                    if (remain_q == 8'd0) state_d = S_IDLE;
                    else                  state_d = is_write_q ? S_WDATA : S_RREQ;
                end
            S_WDATA:
                if (rx_valid_i && (idx_q == 2'd3 || remain_q == 8'd1)) state_d = S_WREQ;
            S_WREQ:
                if (mem_accept_i) state_d = (remain_q != 8'd0) ? S_WDATA : S_IDLE;
            S_RREQ:
                if (mem_accept_i) state_d = mem_ack_i ? S_RSEND : S_RWAIT;
            S_RWAIT: if (mem_ack_i) state_d = S_RSEND;
            S_RSEND:
                if (tx_accept_i && (idx_q == 2'd3 || remain_q == 8'd1))
                    state_d = (remain_q == 8'd1) ? S_IDLE : S_RREQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            remain_q   <= 8'd0;
            idx_q      <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE:
                    if (rx_valid_i) begin
                        if (is_cmd) is_write_q <= (rx_data_i == CMD_WRITE);
                        else        err_q      <= 1'b1;
                    end
                S_LEN:
                    if (rx_valid_i) begin
                        remain_q <= rx_data_i;
                        idx_q    <= 2'd0;
                    end
                S_ADDR:
                    if (rx_valid_i) begin
                        addr_q  <= {addr_q[23:0], rx_data_i};
                        idx_q   <= idx_q + 2'd1;
                        wdata_q <= 32'd0;
                        wstrb_q <= 4'd0;
                    end
                S_WDATA:
                    if (rx_valid_i) begin
                        wdata_q[{lane, 3'b000} +: 8] <= rx_data_i;
                        wstrb_q[lane]                <= 1'b1;
                        remain_q <= (remain_q != 8'd0) ? remain_q - 8'd1 : 8'd0;
                        idx_q    <= idx_q + 2'd1;
                    end
                S_WREQ:
                    if (mem_accept_i) begin
                        addr_q  <= addr_q + 32'd4;
                        wdata_q <= 32'd0;
                        wstrb_q <= 4'd0;
                        idx_q   <= 2'd0;
                    end
                S_RREQ:
                    if (mem_accept_i && mem_ack_i) begin
                        rdata_q <= mem_rdata_i;
                        idx_q   <= 2'd0;
                    end
                S_RWAIT:
                    if (mem_ack_i) begin
                        rdata_q <= mem_rdata_i;
                        idx_q   <= 2'd0;
                    end
                S_RSEND:
                    if (tx_accept_i) begin
                        remain_q <= (remain_q != 8'd0) ? remain_q - 8'd1 : 8'd0;
                        idx_q    <= idx_q + 2'd1;
                        if (idx_q == 2'd3 || remain_q == 8'd1) addr_q <= addr_q + 32'd4;
                    end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted, not just after the edge.
    assign rx_accept_o = rst_i && rx_ready;
    assign tx_valid_o  = rst_i && (state_q == S_RSEND);
    assign tx_data_o   = {8{rst_i}} & rdata_q[{lane, 3'b000} +: 8];
    assign mem_addr_o  = {32{rst_i}} & addr_q;
    assign mem_wr_o    = rst_i && (state_q == S_WREQ);
    assign mem_rd_o    = rst_i && (state_q == S_RREQ);
    assign mem_wdata_o = {32{rst_i}} & wdata_q;
    assign mem_wstrb_o = {4{rst_i}} & wstrb_q;
    assign busy_o      = rst_i && (state_q != S_IDLE);
    assign err_o       = rst_i && err_q;
    assign state_o     = {3{rst_i}} & state_q;

endmodule

// File: tb/tb_dbg_cmd_decoder.sv
// Directed bench for dbg_cmd_decoder: drivers push expected memory/tx traffic
// into queues, a negedge monitor pops and compares each observed transfer.
module tb_dbg_cmd_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_accept_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_accept_i;
    logic [31:0] mem_addr_o;
    logic        mem_wr_o;
    logic        mem_rd_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_accept_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        err_o;
    logic [2:0]  state_o;

    dbg_cmd_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_accept_o(rx_accept_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_accept_i(tx_accept_i),
        .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;
    int err_cycles = 0;
    bit ack_same = 1'b0;
    bit tx_toggle = 1'b0;

    logic [67:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] rd_data_q[$];
    logic [7:0]  exp_tx_q[$];

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (err_o) err_cycles++;
        if (mem_wr_o && mem_accept_i) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got %h expected none",
                         {mem_addr_o, mem_wdata_o, mem_wstrb_o});
            end else begin
                check("write", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, exp_wr_q.pop_front());
            end
            check("wr_rd_excl", {67'd0, mem_rd_o}, 68'd0);
        end
        if (mem_rd_o && mem_accept_i) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_read: got %h expected none", mem_addr_o);
            end else begin
                check("read_addr", {36'd0, mem_addr_o}, {36'd0, exp_rd_q.pop_front()});
            end
        end
        if (tx_valid_o && tx_accept_i) begin
            if (exp_tx_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_tx: got %h expected none", tx_data_o);
            end else begin
                check("tx_byte", {60'd0, tx_data_o}, {60'd0, exp_tx_q.pop_front()});
            end
        end
    end

    // memory read responder
    always @(negedge clk_i) begin
        if (mem_rd_o && mem_accept_i && rd_data_q.size() > 0) begin
            if (ack_same) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd_data_q.pop_front();
                @(posedge clk_i); #1;
                mem_ack_i   = 1'b0;
            end else begin
                @(posedge clk_i); #1;
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd_data_q.pop_front();
                @(posedge clk_i); #1;
                mem_ack_i   = 1'b0;
            end
        end
    end

    // tx sink: always ready, or toggling every cycle
    always @(posedge clk_i) begin
        #1;
        tx_accept_i = tx_toggle ? !tx_accept_i : 1'b1;
    end

    // driver tasks: all start and end at posedge + 1
    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        bit  ok;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            ok = rx_accept_o;
            @(posedge clk_i); #1;
            n++;
        end while (!ok && n < 200);
        rx_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL rx_timeout: got no accept for byte %h expected accept", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (busy_o && n < 300);
        check(name, {67'd0, busy_o}, 68'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0;
        mem_accept_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0; tx_accept_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ctrl", {54'd0, rx_accept_o, tx_valid_o, mem_wr_o, mem_rd_o, busy_o, err_o, tx_data_o}, 68'd0);
        check("reset_bus", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, 68'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("idle_after_reset", {63'd0, rx_accept_o, busy_o, state_o}, {63'd0, 1'b1, 1'b0, 3'd0});
        @(posedge clk_i); #1;

        // 13-byte write at 0x40
        exp_wr_q.push_back({32'h40, 32'h01020304, 4'hF});
        exp_wr_q.push_back({32'h44, 32'h05060708, 4'hF});
        exp_wr_q.push_back({32'h48, 32'h090A0B0C, 4'hF});
        exp_wr_q.push_back({32'h4C, 32'h0D000000, 4'h8});
        send_frame('{8'h10, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h40,
                     8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                     8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D});
        wait_idle("write_frame_idle");
        check("write_frame_drained", {36'd0, exp_wr_q.size()}, 68'd0);

        // 6-byte read at 0x100
        exp_rd_q.push_back(32'h100); exp_rd_q.push_back(32'h104);
        rd_data_q.push_back(32'hAABBCCDD); rd_data_q.push_back(32'h11223344);
        foreach (exp_tx_q[i]) ;
        exp_tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_frame('{8'h11, 8'h06, 8'h00, 8'h00, 8'h01, 8'h00});
        wait_idle("read_frame_idle");
        check("read_frame_tx_drained", {36'd0, exp_tx_q.size()}, 68'd0);
        check("read_frame_rd_drained", {36'd0, exp_rd_q.size()}, 68'd0);

        // unknown command then a zero-length write
        send_byte(8'h55);
        send_frame('{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        wait_idle("err_frame_idle");
        check("err_pulse_cycles", {36'd0, err_cycles}, 68'd1);

        // write stalled by mem_accept_i low for 5 cycles
        mem_accept_i = 1'b0;
        exp_wr_q.push_back({32'h80, 32'hAB000000, 4'h8});
        send_frame('{8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'hAB});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall_wr", {66'd0, mem_wr_o, rx_accept_o}, {66'd0, 1'b1, 1'b0});
            check("stall_bus", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, {32'h80, 32'hAB000000, 4'h8});
        end
        @(posedge clk_i); #1;
        mem_accept_i = 1'b1;
        wait_idle("stall_idle");
        check("stall_drained", {36'd0, exp_wr_q.size()}, 68'd0);

        // 5-byte read, same-cycle ack, toggling tx_accept_i
        tx_toggle = 1'b1;
        ack_same  = 1'b1;
        exp_rd_q.push_back(32'h200); exp_rd_q.push_back(32'h204);
        rd_data_q.push_back(32'h01020304); rd_data_q.push_back(32'h05060708);
        exp_tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame('{8'h11, 8'h05, 8'h00, 8'h00, 8'h02, 8'h00});
        wait_idle("toggle_read_idle");
        tx_toggle = 1'b0;
        ack_same  = 1'b0;
        check("toggle_tx_drained", {36'd0, exp_tx_q.size()}, 68'd0);

        // reset after the 3rd address byte, then a full write
        send_frame('{8'h10, 8'h04, 8'h00, 8'h00, 8'h00});
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midreset_ctrl", {54'd0, rx_accept_o, tx_valid_o, mem_wr_o, mem_rd_o, busy_o, err_o, tx_data_o}, 68'd0);
        check("midreset_bus", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, 68'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midreset_state", {65'd0, state_o}, 68'd0);
        @(posedge clk_i); #1;
        exp_wr_q.push_back({32'h20, 32'h5AA50000, 4'hC});
        send_frame('{8'h10, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20, 8'h5A, 8'hA5});
        wait_idle("post_reset_idle");

        repeat (5) @(posedge clk_i);
        check("final_wr_q_empty", {36'd0, exp_wr_q.size()}, 68'd0);
        check("final_rd_q_empty", {36'd0, exp_rd_q.size()}, 68'd0);
        check("final_tx_q_empty", {36'd0, exp_tx_q.size()}, 68'd0);
        check("final_err_cycles", {36'd0, err_cycles}, 68'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
